regfile_write_sequencer: RTL and testbench

Sequencer and arbiter for the single write port of the 32-entry register file. After reset it clears every register by walking the file with zero writes, then shares the write port between two writeback requesters (ALU path and load path) with valid/ready handshakes and round-robin priority. It drives the register file's `RegWrite`, `write_reg` and `write_data` inputs directly from registered outputs.

---
 rtl/regfile_write_sequencer.sv | 113 +++++++++++
 tb/tb_regfile_write_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_sequencer.sv
// regfile_write_sequencer
// Owns the single write port of the register file. After reset it optionally
// clears every register with a walk of zero writes. It then arbitrates the
// port between two writeback requesters with round-robin priority.
//
// Ports:
//   clk                  rising-edge clock
//   rst                  synchronous active-low reset
//   req0_valid/ready     requester 0 (ALU writeback) handshake; ready is combinational
//   req0_addr/data       requester 0 destination register and write data
//   req1_*               the same set for requester 1 (load writeback)
//   RegWrite             register file write enable (registered)
//   write_reg            register file write address (registered)
//   write_data           register file write data (registered)
//   init_done            high once the clear walk completes; held until reset
//   last_grant           id of the most recently accepted requester
module regfile_write_sequencer #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned NUM_REGS   = 32,
  parameter bit          INIT_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              init_done,
  output logic              last_grant
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              prio;
  logic              run;
  logic              fire0;
  logic              fire1;

  // Priority only matters when both requesters want the port, so a lone
  // requester is always ready; the two readies are never both granted on
  // valid requests in the same cycle.
  assign run        = (state == ST_RUN);
  assign req0_ready = run && (!prio || !req1_valid);
  assign req1_ready = run && ( prio || !req0_valid);
  assign fire0      = req0_valid && req0_ready;
  assign fire1      = req1_valid && req1_ready;

  // Clear walk, arbitration and registered register-file drive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= INIT_CLEAR ? ST_INIT : ST_RUN;
      idx        <= '0;
      prio       <= 1'b0;
      RegWrite   <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
      init_done  <= !INIT_CLEAR;
      last_grant <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          RegWrite   <= 1'b1;
          write_reg  <= idx;
          write_data <= '0;
          // idx parks on the last register instead of wrapping
          if (idx == LAST_IDX) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        ST_RUN: begin
          // $zero is hardwired: the handshake completes but no write is issued
          if (fire0) begin
            RegWrite   <= (req0_addr != '0);
            write_reg  <= req0_addr;
            write_data <= req0_data;
            last_grant <= 1'b0;
            prio       <= 1'b1;
          end else if (fire1) begin
            RegWrite   <= (req1_addr != '0);
            write_reg  <= req1_addr;
            write_data <= req1_data;
            last_grant <= 1'b1;
            prio       <= 1'b0;
          end else begin
            RegWrite <= 1'b0;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Testbench for regfile_write_sequencer: directed steps plus random traffic,
// checked against a transaction-level model and a model register file.
module tb_regfile_write_sequencer;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req1_valid, req1_ready;
  logic [ADDR_W-1:0] req0_addr, req1_addr;
  logic [DATA_W-1:0] req0_data, req1_data;
  logic              RegWrite, init_done, last_grant;
  logic [ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0] write_data;

  always #5 clk = ~clk;

  regfile_write_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .INIT_CLEAR(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_addr(req0_addr), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_addr(req1_addr), .req1_data(req1_data),
    .RegWrite(RegWrite), .write_reg(write_reg), .write_data(write_data),
    .init_done(init_done), .last_grant(last_grant)
  );

  // Register file fed by the DUT outputs
  logic [DATA_W-1:0] rf [NUM_REGS];
  always @(posedge clk) if (RegWrite) rf[write_reg] <= write_data;

  // Reference model
  bit                m_init, m_prio, m_last, m_we, m_done;
  int                m_cnt;
  logic [ADDR_W-1:0] m_reg;
  logic [DATA_W-1:0] m_data;
  logic [DATA_W-1:0] mrf [NUM_REGS];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    m_init = 1'b1; m_cnt = 0; m_prio = 1'b0; m_last = 1'b0;
    m_we = 1'b0; m_reg = '0; m_data = '0; m_done = 1'b0;
  endtask

  // One clock: drive inputs, check readies, clock, advance model, check outputs.
  task automatic cyc(input bit r,
                     input bit v0, input logic [ADDR_W-1:0] a0, input logic [DATA_W-1:0] d0,
                     input bit v1, input logic [ADDR_W-1:0] a1, input logic [DATA_W-1:0] d1);
    int win;
    bit run;
    rst = r;
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    run = !m_init;
    chk("req0_ready", DATA_W'(req0_ready), DATA_W'(run && (!m_prio || !v1)));
    chk("req1_ready", DATA_W'(req1_ready), DATA_W'(run && (m_prio || !v0)));
    if (!run)          win = -1;
    else if (v0 && v1) win = m_prio ? 1 : 0;
    else if (v0)       win = 0;
    else if (v1)       win = 1;
    else               win = -1;
    @(posedge clk);
    if (m_we) mrf[m_reg] = m_data;
    if (!r) begin
      model_reset();
    end else if (m_init) begin
      m_we = 1'b1; m_reg = ADDR_W'(m_cnt); m_data = '0;
      m_cnt++;
      if (m_cnt == int'(NUM_REGS)) begin
        m_init = 1'b0; m_done = 1'b1;
      end
    end else if (win >= 0) begin
      m_reg  = (win == 0) ? a0 : a1;
      m_data = (win == 0) ? d0 : d1;
      m_we   = (m_reg != '0);
      m_last = win[0];
      m_prio = !win[0];
    end else begin
      m_we = 1'b0;
    end
    #1;
    chk("RegWrite",   DATA_W'(RegWrite),   DATA_W'(m_we));
    chk("write_reg",  DATA_W'(write_reg),  DATA_W'(m_reg));
    chk("write_data", write_data,          m_data);
    chk("init_done",  DATA_W'(init_done),  DATA_W'(m_done));
    chk("last_grant", DATA_W'(last_grant), DATA_W'(m_last));
  endtask

  task automatic rnd_cyc(input bit r);
    cyc(r, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom),
           1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)), DATA_W'($urandom));
  endtask

  task automatic idle();
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      rf[i]  = 32'hDEAD_BEEF;
      mrf[i] = 32'hDEAD_BEEF;
    end
    rst = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state, with requests pending
    cyc(1'b0, 1'b1, 5'd4, 32'h4, 1'b1, 5'd6, 32'h6);
    chk("reset_regwrite", DATA_W'(RegWrite), '0);

    // Init walk with random requests that must not be accepted
    for (int i = 0; i < int'(NUM_REGS); i++) rnd_cyc(1'b1);
    chk("init_done_after_walk", DATA_W'(init_done), 32'd1);
    idle();
    chk("rf5_cleared", rf[5], '0);

    // Single requester
    cyc(1'b1, 1'b1, 5'd1, 32'h1, 1'b0, '0, '0);
    chk("single_we",   DATA_W'(RegWrite), 32'd1);
    chk("single_reg",  DATA_W'(write_reg), 32'd1);
    chk("single_data", write_data, 32'd1);
    idle();
    chk("rf1_written", rf[1], 32'd1);

    // $zero suppression (also returns priority to requester 0)
    cyc(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    chk("zero_we", DATA_W'(RegWrite), '0);
    idle();
    chk("rf0_zero", rf[0], '0);

    // Contention: strict 0,1,0,1 interleave
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1, 5'd2, 32'hA, 1'b1, 5'd3, 32'hB);
      chk("contend_grant", DATA_W'(last_grant), DATA_W'(i % 2));
      chk("contend_reg",   DATA_W'(write_reg), (i % 2 == 1) ? 32'd3 : 32'd2);
    end

    // Random traffic
    for (int i = 0; i < 300; i++) rnd_cyc(1'b1);
    for (int i = 0; i < int'(NUM_REGS); i++) chk("rf_contents", rf[i], mrf[i]);

    // Reset mid-RUN right after a transfer
    cyc(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, '0, '0);
    cyc(1'b0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'h10);
    chk("midrun_we",    DATA_W'(RegWrite),   '0);
    chk("midrun_done",  DATA_W'(init_done),  '0);
    chk("midrun_grant", DATA_W'(last_grant), '0);

    // Partial walk, reset mid-INIT, then a full walk
    for (int i = 0; i < 10; i++) rnd_cyc(1'b1);
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    rnd_cyc(1'b1);
    chk("restart_reg", DATA_W'(write_reg), '0);
    for (int i = 1; i < int'(NUM_REGS); i++) begin
      chk("walk_not_done", DATA_W'(init_done), '0);
      rnd_cyc(1'b1);
    end
    chk("rewalk_done", DATA_W'(init_done), 32'd1);

    for (int i = 0; i < 100; i++) rnd_cyc(1'b1);
    idle();
    for (int i = 0; i < int'(NUM_REGS); i++) chk("rf_final", rf[i], mrf[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
